// File: rtl/rv32i_load_store_unit.sv
// ============================================================================
// rv32i_load_store_unit : RV32I memory-stage load/store unit driving a
//   synchronous data RAM port. Optional macro: LSU_MISALIGN_SPLIT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv32i_load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] d_addr,
  output logic        d_we,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic [31:0] d_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS0 = 2'd1,
`ifdef LSU_MISALIGN_SPLIT_EN
    ST_ACCESS1 = 2'd2,
`endif
    ST_RESP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  width_q, width_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic        d_we_q, d_we_d;
  logic [3:0]  d_be_q, d_be_d;
  logic [31:0] d_wdata_q, d_wdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic        split_q, split_d;
  logic [3:0]  be_hi_q, be_hi_d;
  logic [31:0] merge_q, merge_d;
`endif

  logic        w_accept;
  logic [3:0]  w_size_mask;
  logic [1:0]  w_size_m1;
  logic [32:0] w_last;
  logic        w_oob;
  logic        w_misalign;
  logic        w_err;
  logic [3:0]  w_be_lo;
  logic [31:0] w_wdata_m;
  logic [31:0] w_wdata_rot;
  logic [31:0] w_beat;
  logic [31:0] w_rot;
  logic [31:0] w_load;

  assign w_accept = req_valid && (state_q == ST_IDLE);

  always_comb begin
    w_size_mask = 4'b0000;
    w_size_m1   = 2'd0;
    case (req_width)
      2'd0:    begin w_size_mask = 4'b0001; w_size_m1 = 2'd0; end
      2'd1:    begin w_size_mask = 4'b0011; w_size_m1 = 2'd1; end
      2'd2:    begin w_size_mask = 4'b1111; w_size_m1 = 2'd3; end
      default: begin w_size_mask = 4'b0000; w_size_m1 = 2'd0; end
    endcase
  end

  // 33-bit sum so an access near the top of the address space cannot wrap.
  assign w_last = {1'b0, req_addr} + {31'd0, w_size_m1};
  assign w_oob  = (w_last >= 33'(MEM_BYTES));

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [7:0] w_be_wide;
  logic [3:0] w_be_hi;
  assign w_be_wide  = {4'd0, w_size_mask} << req_addr[1:0];
  assign w_be_lo    = w_be_wide[3:0];
  assign w_be_hi    = w_be_wide[7:4];
  assign w_misalign = 1'b0;
`else
  assign w_be_lo    = w_size_mask << req_addr[1:0];
  assign w_misalign = ((req_width == 2'd1) && req_addr[0]) ||
                      ((req_width == 2'd2) && (req_addr[1:0] != 2'd0));
`endif

  assign w_err = (req_width == 2'd3) || w_misalign || w_oob;

  // Unused upper bytes are cleared before rotation so idle lanes carry zero.
  always_comb begin
    w_wdata_m = req_wdata;
    case (req_width)
      2'd0:    w_wdata_m = {24'd0, req_wdata[7:0]};
      2'd1:    w_wdata_m = {16'd0, req_wdata[15:0]};
      default: w_wdata_m = req_wdata;
    endcase
  end

  always_comb begin
    w_wdata_rot = w_wdata_m;
    case (req_addr[1:0])
      2'd0:    w_wdata_rot = w_wdata_m;
      2'd1:    w_wdata_rot = {w_wdata_m[23:0], w_wdata_m[31:24]};
      2'd2:    w_wdata_rot = {w_wdata_m[15:0], w_wdata_m[31:16]};
      default: w_wdata_rot = {w_wdata_m[7:0],  w_wdata_m[31:8]};
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Lanes at or above the offset came from the first word (held in merge_q).
  always_comb begin
    w_beat = d_rdata;
    if (split_q) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) >= off_q) w_beat[8*i +: 8] = merge_q[8*i +: 8];
      end
    end
  end
`else
  assign w_beat = d_rdata;
`endif

  always_comb begin
    w_rot = w_beat;
    case (off_q)
      2'd0:    w_rot = w_beat;
      2'd1:    w_rot = {w_beat[7:0],  w_beat[31:8]};
      2'd2:    w_rot = {w_beat[15:0], w_beat[31:16]};
      default: w_rot = {w_beat[23:0], w_beat[31:24]};
    endcase
  end

  always_comb begin
    w_load = w_rot;
    case (width_q)
      2'd0:    w_load = {{24{sign_q & w_rot[7]}},  w_rot[7:0]};
      2'd1:    w_load = {{16{sign_q & w_rot[15]}}, w_rot[15:0]};
      default: w_load = w_rot;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    width_d      = width_q;
    sign_d       = sign_q;
    off_d        = off_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    d_addr_d     = 32'd0;
    d_we_d       = 1'b0;
    d_be_d       = 4'd0;
    d_wdata_d    = 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d      = split_q;
    be_hi_d      = be_hi_q;
    merge_d      = merge_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          we_d    = req_we;
          width_d = req_width;
          sign_d  = req_sign;
          off_d   = req_addr[1:0];
          err_d   = w_err;
          if (w_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d   = ST_ACCESS0;
            d_addr_d  = {req_addr[31:2], 2'b00};
            d_we_d    = req_we;
            d_be_d    = w_be_lo;
            d_wdata_d = w_wdata_rot;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_d   = (w_be_hi != 4'd0);
            be_hi_d   = w_be_hi;
`endif
          end
        end
      end
      ST_ACCESS0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q) begin
          state_d   = ST_ACCESS1;
          d_addr_d  = d_addr_q + 32'd4;
          d_we_d    = we_q;
          d_be_d    = be_hi_q;
          d_wdata_d = d_wdata_q;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
        end
`else
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_ACCESS1: begin
        merge_d      = d_rdata;
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
`endif
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      width_q      <= 2'd0;
      sign_q       <= 1'b0;
      off_q        <= 2'd0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      d_addr_q     <= 32'd0;
      d_we_q       <= 1'b0;
      d_be_q       <= 4'd0;
      d_wdata_q    <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q      <= 1'b0;
      be_hi_q      <= 4'd0;
      merge_q      <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      width_q      <= width_d;
      sign_q       <= sign_d;
      off_q        <= off_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      d_addr_q     <= d_addr_d;
      d_we_q       <= d_we_d;
      d_be_q       <= d_be_d;
      d_wdata_q    <= d_wdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q      <= split_d;
      be_hi_q      <= be_hi_d;
      merge_q      <= merge_d;
`endif
    end
  end

  // Read data arrives from the RAM during RESP, so the result is formed from it directly.
  assign resp_rdata = ((state_q == ST_RESP) && !err_q && !we_q) ? w_load : 32'd0;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign d_addr     = d_addr_q;
  assign d_we       = d_we_q;
  assign d_be       = d_be_q;
  assign d_wdata    = d_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_load_store_unit.sv
// ============================================================================
// tb_rv32i_load_store_unit : directed table, reset corner case and random
//   traffic for rv32i_load_store_unit against a byte-array memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rv32i_load_store_unit;

  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_width;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        ram_clr;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [MEM_WORDS];
  logic [7:0]  ref_mem [MEM_BYTES];

  rv32i_load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_width  (req_width),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .d_addr     (d_addr),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data for the address presented appears next cycle.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] <= 32'd0;
      d_rdata <= 32'd0;
    end else begin
      if (d_we) begin
        for (int l = 0; l < 4; l++) begin
          if (d_be[l]) ram[d_addr[11:2]][8*l +: 8] <= d_wdata[8*l +: 8];
        end
      end
      d_rdata <= ram[d_addr[11:2]];
    end
  end

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drives one request and checks every cycle until ready returns.
  task automatic run_req(input logic we, input logic [1:0] width, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] o_rdata, output logic o_err,
                         output logic [3:0] o_be0, output logic [31:0] o_wd0);
    int          size;
    int          nb;
    int          lat;
    bit          err;
    longint      last;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be [2];
    logic [31:0] exp_a  [2];
    size = (width == 2'd3) ? 1 : (1 << width);
    last = longint'(addr) + longint'(size) - 1;
    err  = (width == 2'd3) || (last >= longint'(MEM_BYTES)) ||
           (!SPLIT && ((addr % size) != 0));
    nb   = err ? 0 : ((int'(addr % 4) + size > 4) ? 2 : 1);
    lat  = err ? 1 : nb + 1;
    exp_wd    = 32'd0;
    exp_be[0] = 4'd0;
    exp_be[1] = 4'd0;
    exp_a[0]  = addr & ~32'd3;
    exp_a[1]  = (addr & ~32'd3) + 32'd4;
    for (int k = 0; k < size; k++) begin
      int lane;
      int b;
      lane = int'((addr + 32'(k)) % 4);
      b    = int'(((addr + 32'(k)) >> 2) - (addr >> 2));
      exp_wd[8*lane +: 8] = wdata[8*k +: 8];
      if (b < 2) exp_be[b][lane] = 1'b1;
    end
    exp_rd = 32'd0;
    if (!err && !we) begin
      for (int k = 0; k < size; k++) exp_rd[8*k +: 8] = ref_mem[addr + 32'(k)];
      if (sign && exp_rd[8*size-1]) begin
        for (int k = size; k < 4; k++) exp_rd[8*k +: 8] = 8'hFF;
      end
    end
    if (!err && we) begin
      for (int k = 0; k < size; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
    end

    @(negedge clk);
    check("ready_before", 72'(req_ready), 72'(1'b1));
    req_valid = 1'b1;
    req_we    = we;
    req_width = width;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    o_rdata = 32'd0;
    o_err   = 1'b0;
    o_be0   = 4'd0;
    o_wd0   = 32'd0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c <= nb) begin
        check("beat", 72'({d_we, d_be, d_addr, d_wdata}),
              72'({we, exp_be[c-1], exp_a[c-1], exp_wd}));
        check("beat_ctl", 72'({resp_valid, req_ready}), 72'(2'b00));
        if (c == 1) begin
          o_be0 = d_be;
          o_wd0 = d_wdata;
        end
      end else if (c == lat) begin
        check("resp", 72'({resp_valid, resp_err, resp_rdata, d_we, d_be, req_ready}),
              72'({1'b1, err, exp_rd, 1'b0, 4'd0, 1'b0}));
        o_rdata = resp_rdata;
        o_err   = resp_err;
      end else begin
        check("after_resp", 72'({req_ready, resp_valid, d_we}), 72'(3'b100));
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic we, input logic [1:0] width, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
    vec_t v;
    v.we = we; v.width = width; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_be = exp_be; v.exp_wd = exp_wd;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [3:0]  be0;
    logic [31:0] wd0;

    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'd0;
    reset     = 1'b1;
    ram_clr   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_width = 2'd0;
    req_sign  = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 72'({req_ready, resp_valid, resp_err, resp_rdata, d_we, d_be, d_addr}),
          72'({1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0}));
    reset   = 1'b0;
    ram_clr = 1'b0;
    @(negedge clk);
    check("reset_wdata", 72'(d_wdata), 72'(32'd0));

    // we width sign addr wdata | err rdata be wdata
    add_vec(1, 2'd0, 0, 32'h50, 32'h00000080, 0, 32'h0,        4'b0001, 32'h00000080);
    add_vec(0, 2'd0, 0, 32'h50, 32'h0,        0, 32'h00000080, 4'b0001, 32'h0);
    add_vec(1, 2'd1, 0, 32'h52, 32'hFFFFFFFB, 0, 32'h0,        4'b1100, 32'hFFFB0000);
    add_vec(0, 2'd1, 1, 32'h52, 32'h0,        0, 32'hFFFFFFFB, 4'b1100, 32'h0);
    add_vec(0, 2'd1, 0, 32'h52, 32'h0,        0, 32'h0000FFFB, 4'b1100, 32'h0);
    add_vec(1, 2'd2, 0, 32'h0C, 32'h12345678, 0, 32'h0,        4'b1111, 32'h12345678);
    add_vec(0, 2'd2, 0, 32'h0C, 32'h0,        0, 32'h12345678, 4'b1111, 32'h0);
    add_vec(0, 2'd3, 0, 32'h10, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
    add_vec(0, 2'd2, 0, MEM_BYTES - 2, 32'h0, 1, 32'h0,        4'b0000, 32'h0);
    add_vec(0, 2'd2, 0, MEM_BYTES - 4, 32'h0, 0, 32'h0,        4'b1111, 32'h0);
    add_vec(1, 2'd0, 0, MEM_BYTES - 1, 32'h000000A5, 0, 32'h0, 4'b1000, 32'hA5000000);
    add_vec(0, 2'd0, 1, MEM_BYTES - 1, 32'h0, 0, 32'hFFFFFFA5, 4'b1000, 32'h0);
    add_vec(1, 2'd1, 0, MEM_BYTES,     32'h1234, 1, 32'h0,     4'b0000, 32'h0);
    if (SPLIT) begin
      add_vec(1, 2'd2, 0, 32'h51, 32'h12345678, 0, 32'h0,        4'b1110, 32'h34567812);
      add_vec(0, 2'd2, 0, 32'h51, 32'h0,        0, 32'h12345678, 4'b1110, 32'h0);
    end else begin
      add_vec(1, 2'd2, 0, 32'h51, 32'h12345678, 1, 32'h0,        4'b0000, 32'h0);
      add_vec(0, 2'd2, 0, 32'h51, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      run_req(vecs[i].we, vecs[i].width, vecs[i].sign, vecs[i].addr, vecs[i].wdata,
              rd, er, be0, wd0);
      check($sformatf("vec%0d", i), 72'({er, rd, be0, wd0}),
            72'({vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_be, vecs[i].exp_wd}));
    end

    // Reset during ACCESS0 of a store: strobe drops at once, store is lost.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_width = 2'd2;
    req_sign  = 1'b0;
    req_addr  = 32'h20;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_we", 72'({d_we, d_be}), 72'(5'b11111));
    reset = 1'b1;
    #1;
    check("rst_drop", 72'({d_we, d_be}), 72'(5'b00000));
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_after", 72'({req_ready, resp_valid}), 72'(2'b10));
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, be0, wd0);

    // Random traffic checked by the byte-array model inside run_req.
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [1:0]  width;
      logic        sign;
      logic [31:0] addr;
      we    = 1'($urandom_range(0, 1));
      sign  = 1'($urandom_range(0, 1));
      width = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0)
        addr = MEM_BYTES - 32'($urandom_range(1, 8));
      else
        addr = 32'h200 + 32'($urandom_range(0, 63));
      if (!SPLIT && width != 2'd3 && $urandom_range(0, 3) != 0)
        addr = addr & ~((32'd1 << width) - 32'd1);
      run_req(we, width, sign, addr, $urandom, rd, er, be0, wd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
